// File: rtl/hazard_unit.sv
// Hazard and forwarding unit for the five-stage pipeline: register-tag pipeline,
// operand forwarding selects, load-use / PC-write / memory-wait stall and flush control.
module hazard_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CW          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] WA3D,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    input  logic       IgRnE,
    input  logic       MemAccessM,
    input  logic       MemReady,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MemErr
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} mem_state_t;

    mem_state_t    r_state;
    mem_state_t    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_mem_err;

    logic       r_ve, r_vm, r_vw;
    logic [3:0] r_ra1e, r_ra2e, r_wa3e, r_wa3m, r_wa3w;

    logic w_mem_stall, w_ld_stall, w_pc_pend;
    logic w_stall_e, w_flush_e;

    // Memory wait/timeout next-state; stall only while the access is still not ready
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (MemAccessM & ~MemReady) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = {{(CW-1){1'b0}}, 1'b1};
                    w_mem_stall = 1'b1;
                end else begin
                    w_cnt_nxt   = {CW{1'b0}};
                end
            end
            S_WAIT: begin
                if (MemReady) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_mem_stall = 1'b1;
                    if (r_cnt == CW'(MEM_TIMEOUT)) begin
                        w_state_nxt = S_ERR;
                        w_cnt_nxt   = {CW{1'b0}};
                    end else begin
                        w_cnt_nxt   = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Memory FSM state, wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_state_nxt == S_ERR) begin
                r_mem_err <= 1'b1;
            end else begin
                r_mem_err <= r_mem_err;
            end
        end
    end

    // Stall and flush decode; a memory stall masks every flush until it releases
    always_comb begin
        w_ld_stall = MemtoRegE & r_ve & ((RA1D == r_wa3e) | (RA2D == r_wa3e));
        w_pc_pend  = PCSrcD | PCSrcE | PCSrcM;
        w_stall_e  = w_mem_stall;
        w_flush_e  = (w_ld_stall | BranchTakenE) & ~w_mem_stall;
        StallF     = w_ld_stall | w_pc_pend | w_mem_stall;
        StallD     = w_ld_stall | w_mem_stall;
        StallE     = w_stall_e;
        FlushD     = (w_pc_pend | PCSrcW | BranchTakenE) & ~w_mem_stall;
        FlushE     = w_flush_e;
        MemErr     = r_mem_err;
    end

    // Register-tag pipeline D->E->M->W; W is invalidated while the back end is frozen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ve   <= 1'b0;
            r_vm   <= 1'b0;
            r_vw   <= 1'b0;
            r_ra1e <= 4'd0;
            r_ra2e <= 4'd0;
            r_wa3e <= 4'd0;
            r_wa3m <= 4'd0;
            r_wa3w <= 4'd0;
        end else if (!w_stall_e) begin
            r_ve   <= ~w_flush_e;
            r_ra1e <= RA1D;
            r_ra2e <= RA2D;
            r_wa3e <= WA3D;
            r_vm   <= r_ve;
            r_wa3m <= r_wa3e;
            r_vw   <= r_vm;
            r_wa3w <= r_wa3m;
        end else begin
            r_vw   <= 1'b0;
        end
    end

    // Forwarding selects: memory-stage result wins over write-back
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (IgRnE) begin
            ForwardAE = 2'b00;
        end else if (r_ve & r_vm & (r_ra1e == r_wa3m) & RegWriteM) begin
            ForwardAE = 2'b10;
        end else if (r_ve & r_vw & (r_ra1e == r_wa3w) & RegWriteW) begin
            ForwardAE = 2'b01;
        end else begin
            ForwardAE = 2'b00;
        end
        if (r_ve & r_vm & (r_ra2e == r_wa3m) & RegWriteM) begin
            ForwardBE = 2'b10;
        end else if (r_ve & r_vw & (r_ra2e == r_wa3w) & RegWriteW) begin
            ForwardBE = 2'b01;
        end else begin
            ForwardBE = 2'b00;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TIMEOUT reduced to 4).
module tb_hazard_unit;

    logic       clk;
    logic       reset;
    logic [3:0] RA1D, RA2D, WA3D;
    logic       RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic       BranchTakenE, IgRnE, MemAccessM, MemReady;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, FlushD, FlushE, MemErr;

    int n_checks = 0;
    int n_errors = 0;

    hazard_unit #(.MEM_TIMEOUT(4), .CW(8)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .IgRnE(IgRnE),
        .MemAccessM(MemAccessM), .MemReady(MemReady),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .MemErr(MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3);
        RA1D = ra1;
        RA2D = ra2;
        WA3D = wa3;
    endtask

    initial begin
        reset = 1'b0;
        set_d(4'd0, 4'd0, 4'd0);
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
        PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
        BranchTakenE = 1'b0; IgRnE = 1'b0; MemAccessM = 1'b0; MemReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_fwd_a", ForwardAE, 8'd0);
        check_val("rst_fwd_b", ForwardBE, 8'd0);
        check_val("rst_stall_f", StallF, 8'd0);
        check_val("rst_flush_e", FlushE, 8'd0);
        check_val("rst_mem_err", MemErr, 8'd0);
        @(negedge clk);
        reset = 1'b1;

        // producer, producer, consumer of R1
        set_d(4'd0, 4'd0, 4'd1); @(negedge clk);
        set_d(4'd0, 4'd0, 4'd1); @(negedge clk);
        set_d(4'd1, 4'd1, 4'd5); @(negedge clk);
        set_d(4'd0, 4'd0, 4'd0);
        RegWriteM = 1'b1; RegWriteW = 1'b0; #1;
        check_val("fwd_a_m", ForwardAE, 8'd2);
        check_val("fwd_b_m", ForwardBE, 8'd2);
        RegWriteM = 1'b0; RegWriteW = 1'b1; #1;
        check_val("fwd_a_w", ForwardAE, 8'd1);
        RegWriteM = 1'b1; #1;
        check_val("fwd_a_both", ForwardAE, 8'd2);
        IgRnE = 1'b1; #1;
        check_val("fwd_a_igrn", ForwardAE, 8'd0);
        check_val("fwd_b_igrn", ForwardBE, 8'd2);
        IgRnE = 1'b0;
        @(negedge clk); #1;
        check_val("fwd_a_nomatch", ForwardAE, 8'd0);

        // load R2 followed by a use of R2
        set_d(4'd0, 4'd0, 4'd2); @(negedge clk);
        set_d(4'd0, 4'd2, 4'd7); MemtoRegE = 1'b1; #1;
        check_val("ld_stall_f", StallF, 8'd1);
        check_val("ld_stall_d", StallD, 8'd1);
        check_val("ld_flush_e", FlushE, 8'd1);
        check_val("ld_stall_e", StallE, 8'd0);
        check_val("ld_flush_d", FlushD, 8'd0);
        @(negedge clk);
        MemtoRegE = 1'b0; #1;
        check_val("ld_rel_stall_f", StallF, 8'd0);
        check_val("ld_rel_stall_d", StallD, 8'd0);
        check_val("ld_rel_flush_e", FlushE, 8'd0);
        check_val("ld_bubble_fwd_b", ForwardBE, 8'd0);
        @(negedge clk);
        set_d(4'd0, 4'd0, 4'd0); #1;
        check_val("ld_use_fwd_b", ForwardBE, 8'd1);
        @(negedge clk);
        RegWriteM = 1'b0; RegWriteW = 1'b0;

        // PC-writing instruction walking D->E->M->W
        PCSrcD = 1'b1; #1;
        check_val("pc_d_stall_f", StallF, 8'd1);
        check_val("pc_d_flush_d", FlushD, 8'd1);
        check_val("pc_d_stall_d", StallD, 8'd0);
        @(negedge clk);
        PCSrcD = 1'b0; PCSrcE = 1'b1; #1;
        check_val("pc_e_stall_f", StallF, 8'd1);
        check_val("pc_e_flush_d", FlushD, 8'd1);
        @(negedge clk);
        PCSrcE = 1'b0; PCSrcM = 1'b1; #1;
        check_val("pc_m_stall_f", StallF, 8'd1);
        check_val("pc_m_flush_d", FlushD, 8'd1);
        @(negedge clk);
        PCSrcM = 1'b0; PCSrcW = 1'b1; #1;
        check_val("pc_w_stall_f", StallF, 8'd0);
        check_val("pc_w_flush_d", FlushD, 8'd1);
        @(negedge clk);
        PCSrcW = 1'b0; set_d(4'd0, 4'd0, 4'd5); #1;
        check_val("pc_done_stall_f", StallF, 8'd0);
        check_val("pc_done_flush_d", FlushD, 8'd0);
        @(negedge clk);

        // taken branch squashes the consumer of R5
        set_d(4'd5, 4'd0, 4'd0); BranchTakenE = 1'b1; #1;
        check_val("br_flush_d", FlushD, 8'd1);
        check_val("br_flush_e", FlushE, 8'd1);
        check_val("br_stall_d", StallD, 8'd0);
        @(negedge clk);
        BranchTakenE = 1'b0; RegWriteM = 1'b1; set_d(4'd0, 4'd0, 4'd9); #1;
        check_val("br_flushed_fwd_a", ForwardAE, 8'd0);
        @(negedge clk);
        set_d(4'd9, 4'd9, 4'd0);
        @(negedge clk);

        // memory not ready for three cycles
        set_d(4'd0, 4'd0, 4'd0);
        MemAccessM = 1'b1; MemReady = 1'b0; RegWriteM = 1'b1; RegWriteW = 1'b1; #1;
        check_val("mw1_stall_e", StallE, 8'd1);
        check_val("mw1_stall_f", StallF, 8'd1);
        check_val("mw1_stall_d", StallD, 8'd1);
        check_val("mw1_flush_d", FlushD, 8'd0);
        check_val("mw1_fwd_a", ForwardAE, 8'd2);
        @(negedge clk); #1;
        check_val("mw2_stall_e", StallE, 8'd1);
        RegWriteM = 1'b0; #1;
        check_val("mw2_w_invalid", ForwardAE, 8'd0);
        RegWriteM = 1'b1;
        @(negedge clk); #1;
        check_val("mw3_stall_e", StallE, 8'd1);
        check_val("mw3_fwd_b", ForwardBE, 8'd2);
        @(negedge clk);
        MemReady = 1'b1; #1;
        check_val("mw_rel_stall_e", StallE, 8'd0);
        check_val("mw_rel_stall_f", StallF, 8'd0);
        check_val("mw_rel_fwd_a", ForwardAE, 8'd2);
        check_val("mw_rel_mem_err", MemErr, 8'd0);
        @(negedge clk);

        // memory stuck not ready: timeout after five stalled cycles
        RegWriteM = 1'b0; RegWriteW = 1'b0; MemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val($sformatf("to_stall_%0d", i), StallE, 8'd1);
            @(negedge clk);
        end
        #1;
        check_val("to_release", StallE, 8'd0);
        check_val("to_mem_err", MemErr, 8'd1);
        @(negedge clk); #1;
        check_val("to_restall", StallE, 8'd1);
        check_val("to_err_sticky", MemErr, 8'd1);
        @(negedge clk);
        MemAccessM = 1'b0; #1;
        check_val("wait_state_stall", StallE, 8'd1);
        reset = 1'b0; #1;
        check_val("rst_async_stall_e", StallE, 8'd0);
        check_val("rst_async_stall_f", StallF, 8'd0);
        check_val("rst_async_mem_err", MemErr, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
